// File: rtl/fft8_radix2_pipe.sv
// ---------------------------------------------------------------------------
// fft8_radix2_pipe
//
// Pipelined 8-point radix-2 decimation-in-time FFT on complex signed
// fixed-point samples. One 8-sample frame is accepted per cycle and the
// transform result appears three cycles later (three register stages,
// S1..S3, with S3 driving the outputs directly).
//
// Parameters
//   W      data width of each real/imag sample (signed two's complement)
//   TW     twiddle width; c = round(0.70710678 * 2^(TW-1))
//   SCALE  1: arithmetic >>1 after every butterfly stage (output = DFT/8)
//          0: no scaling, stage results keep their low W bits
//
// Optional feature (compile-time macro FFT8_SATURATE_EN)
//   defined   : every W+1-bit stage result (SCALE=0) and every twiddle
//               product clamps to [-2^(W-1), 2^(W-1)-1]
//   undefined : two's-complement wrap, no clamp logic is built
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   input frame valid
//   in_ready   out  pipeline accepts a frame this cycle
//   in_re/im   in   x[n] at bits [n*W +: W], natural order
//   out_valid  out  output frame valid
//   out_ready  in   downstream accepts the frame
//   out_re/im  out  X[k] at bits [k*W +: W], natural order
//
// Handshake: a frame moves on a side when valid and ready are both high at
// the rising edge. The whole pipeline shares one enable,
// en = ~out_valid | out_ready, which is also in_ready; every stage advances
// together only when en is high, so a frame held at the output with
// out_ready low stays stable until it is taken. An idle input cycle with
// en high enters the pipe as a bubble (valid low; its data is don't-care).
// ---------------------------------------------------------------------------
module fft8_radix2_pipe #(
  parameter int W     = 16,
  parameter int TW    = 16,
  parameter int SCALE = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [8*W-1:0] in_re,
  input  logic [8*W-1:0] in_im,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [8*W-1:0] out_re,
  output logic [8*W-1:0] out_im
);

  // Product width: W+1-bit operand times TW-bit coefficient plus headroom.
  localparam int PW = W + TW + 2;

  // c = round(0.70710678 * 2^(TW-1)), computed in integer arithmetic.
  localparam logic [63:0] C_L =
    (64'd70710678 * (64'd1 << (TW - 1)) + 64'd50000000) / 64'd100000000;
  localparam logic signed [TW-1:0] C_TW = C_L[TW-1:0];

  // Round-half-up offset applied before the >>> (TW-1).
  localparam logic signed [PW-1:0] RND =
    {{(PW-TW+1){1'b0}}, 1'b1, {(TW-2){1'b0}}};

`ifdef FFT8_SATURATE_EN
  localparam logic signed [W:0]    S_MAX = {2'b00, {(W-1){1'b1}}};
  localparam logic signed [W:0]    S_MIN = {2'b11, {(W-1){1'b0}}};
  localparam logic signed [PW-1:0] P_MAX = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] P_MIN = {{(PW-W+1){1'b1}}, {(W-1){1'b0}}};
`endif

  // -------------------------------------------------------------------------
  // Arithmetic helpers
  // -------------------------------------------------------------------------
  function automatic logic signed [W:0] wide_add(input logic signed [W-1:0] a,
                                                 input logic signed [W-1:0] b);
    return {a[W-1], a} + {b[W-1], b};
  endfunction

  function automatic logic signed [W:0] wide_sub(input logic signed [W-1:0] a,
                                                 input logic signed [W-1:0] b);
    return {a[W-1], a} - {b[W-1], b};
  endfunction

  // Reduce a W+1-bit stage result back to W bits.
  function automatic logic signed [W-1:0] fit_sum(input logic signed [W:0] s);
    logic signed [W-1:0] r;
    if (SCALE != 0) begin
      r = s[W:1];
    end else begin
`ifdef FFT8_SATURATE_EN
      if (s > S_MAX)      r = {1'b0, {(W-1){1'b1}}};
      else if (s < S_MIN) r = {1'b1, {(W-1){1'b0}}};
      else                r = s[W-1:0];
`else
      r = s[W-1:0];
`endif
    end
    return r;
  endfunction

  // (+/-) c * s, with s already the full-width real/imag sum, rounded half up.
  function automatic logic signed [W-1:0] tw_mul(input logic signed [W:0] s,
                                                 input logic              neg);
    logic signed [PW-1:0] se;
    logic signed [PW-1:0] ce;
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] q;
    logic signed [W-1:0]  r;
    se = {{(PW-W-1){s[W]}}, s};
    ce = {{(PW-TW){C_TW[TW-1]}}, C_TW};
    p  = se * ce;
    if (neg) p = -p;
    q = (p + RND) >>> (TW - 1);
`ifdef FFT8_SATURATE_EN
    if (q > P_MAX)      r = {1'b0, {(W-1){1'b1}}};
    else if (q < P_MIN) r = {1'b1, {(W-1){1'b0}}};
    else                r = q[W-1:0];
`else
    r = q[W-1:0];
`endif
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Flow control
  // -------------------------------------------------------------------------
  logic en;
  logic s1_valid, s2_valid, s3_valid;

  assign en        = ~s3_valid | out_ready;
  assign in_ready  = en;
  assign out_valid = s3_valid;

  // -------------------------------------------------------------------------
  // Stage data
  // -------------------------------------------------------------------------
  logic signed [W-1:0] x_re [8];
  logic signed [W-1:0] x_im [8];
  logic signed [W-1:0] g_re [8];
  logic signed [W-1:0] g_im [8];
  logic signed [W-1:0] h_re [8];
  logic signed [W-1:0] h_im [8];
  logic signed [W-1:0] y_re [8];
  logic signed [W-1:0] y_im [8];

  logic signed [W-1:0] s1_re [8];
  logic signed [W-1:0] s1_im [8];
  logic signed [W-1:0] s2_re [8];
  logic signed [W-1:0] s2_im [8];
  logic signed [W-1:0] s3_re [8];
  logic signed [W-1:0] s3_im [8];

  logic signed [W-1:0] t1_re, t1_im, t3_re, t3_im;

  always_comb begin
    for (int n = 0; n < 8; n++) begin
      x_re[n] = in_re[n*W +: W];
      x_im[n] = in_im[n*W +: W];
    end
  end

  // S1: length-2 butterflies on input pairs (n, n+4).
  always_comb begin
    g_re[0] = fit_sum(wide_add(x_re[0], x_re[4]));
    g_im[0] = fit_sum(wide_add(x_im[0], x_im[4]));
    g_re[1] = fit_sum(wide_sub(x_re[0], x_re[4]));
    g_im[1] = fit_sum(wide_sub(x_im[0], x_im[4]));
    g_re[2] = fit_sum(wide_add(x_re[2], x_re[6]));
    g_im[2] = fit_sum(wide_add(x_im[2], x_im[6]));
    g_re[3] = fit_sum(wide_sub(x_re[2], x_re[6]));
    g_im[3] = fit_sum(wide_sub(x_im[2], x_im[6]));
    g_re[4] = fit_sum(wide_add(x_re[1], x_re[5]));
    g_im[4] = fit_sum(wide_add(x_im[1], x_im[5]));
    g_re[5] = fit_sum(wide_sub(x_re[1], x_re[5]));
    g_im[5] = fit_sum(wide_sub(x_im[1], x_im[5]));
    g_re[6] = fit_sum(wide_add(x_re[3], x_re[7]));
    g_im[6] = fit_sum(wide_add(x_im[3], x_im[7]));
    g_re[7] = fit_sum(wide_sub(x_re[3], x_re[7]));
    g_im[7] = fit_sum(wide_sub(x_im[3], x_im[7]));
  end

  // S2: length-4 butterflies. The -j factor is folded into the add/sub
  // (-j*z = (z.im, -z.re)), so no separate negation step exists to wrap.
  always_comb begin
    h_re[0] = fit_sum(wide_add(s1_re[0], s1_re[2]));
    h_im[0] = fit_sum(wide_add(s1_im[0], s1_im[2]));
    h_re[2] = fit_sum(wide_sub(s1_re[0], s1_re[2]));
    h_im[2] = fit_sum(wide_sub(s1_im[0], s1_im[2]));
    h_re[1] = fit_sum(wide_add(s1_re[1], s1_im[3]));
    h_im[1] = fit_sum(wide_sub(s1_im[1], s1_re[3]));
    h_re[3] = fit_sum(wide_sub(s1_re[1], s1_im[3]));
    h_im[3] = fit_sum(wide_add(s1_im[1], s1_re[3]));
    h_re[4] = fit_sum(wide_add(s1_re[4], s1_re[6]));
    h_im[4] = fit_sum(wide_add(s1_im[4], s1_im[6]));
    h_re[6] = fit_sum(wide_sub(s1_re[4], s1_re[6]));
    h_im[6] = fit_sum(wide_sub(s1_im[4], s1_im[6]));
    h_re[5] = fit_sum(wide_add(s1_re[5], s1_im[7]));
    h_im[5] = fit_sum(wide_sub(s1_im[5], s1_re[7]));
    h_re[7] = fit_sum(wide_sub(s1_re[5], s1_im[7]));
    h_im[7] = fit_sum(wide_add(s1_im[5], s1_re[7]));
  end

  // S3 twiddles.
  //   W8^1 * z = (c*(re+im), c*(im-re))
  //   W8^3 * z = (c*(im-re), -c*(re+im))
  // Each sum is formed at W+1 bits before the multiply and rounding.
  always_comb begin
    t1_re = tw_mul(wide_add(s2_re[5], s2_im[5]), 1'b0);
    t1_im = tw_mul(wide_sub(s2_im[5], s2_re[5]), 1'b0);
    t3_re = tw_mul(wide_sub(s2_im[7], s2_re[7]), 1'b0);
    t3_im = tw_mul(wide_add(s2_re[7], s2_im[7]), 1'b1);
  end

  // S3: final butterflies X[k], X[k+4].
  always_comb begin
    y_re[0] = fit_sum(wide_add(s2_re[0], s2_re[4]));
    y_im[0] = fit_sum(wide_add(s2_im[0], s2_im[4]));
    y_re[4] = fit_sum(wide_sub(s2_re[0], s2_re[4]));
    y_im[4] = fit_sum(wide_sub(s2_im[0], s2_im[4]));
    y_re[1] = fit_sum(wide_add(s2_re[1], t1_re));
    y_im[1] = fit_sum(wide_add(s2_im[1], t1_im));
    y_re[5] = fit_sum(wide_sub(s2_re[1], t1_re));
    y_im[5] = fit_sum(wide_sub(s2_im[1], t1_im));
    // W8^2 = -j: exact, folded into the add/sub like in S2.
    y_re[2] = fit_sum(wide_add(s2_re[2], s2_im[6]));
    y_im[2] = fit_sum(wide_sub(s2_im[2], s2_re[6]));
    y_re[6] = fit_sum(wide_sub(s2_re[2], s2_im[6]));
    y_im[6] = fit_sum(wide_add(s2_im[2], s2_re[6]));
    y_re[3] = fit_sum(wide_add(s2_re[3], t3_re));
    y_im[3] = fit_sum(wide_add(s2_im[3], t3_im));
    y_re[7] = fit_sum(wide_sub(s2_re[3], t3_re));
    y_im[7] = fit_sum(wide_sub(s2_im[3], t3_im));
  end

  // -------------------------------------------------------------------------
  // Pipeline registers. Reset discards everything in flight and zeroes the
  // output registers; data of bubble stages still loads when enabled.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        s1_re[i] <= '0;
        s1_im[i] <= '0;
        s2_re[i] <= '0;
        s2_im[i] <= '0;
        s3_re[i] <= '0;
        s3_im[i] <= '0;
      end
    end else if (en) begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
      for (int i = 0; i < 8; i++) begin
        s1_re[i] <= g_re[i];
        s1_im[i] <= g_im[i];
        s2_re[i] <= h_re[i];
        s2_im[i] <= h_im[i];
        s3_re[i] <= y_re[i];
        s3_im[i] <= y_im[i];
      end
    end
  end

  always_comb begin
    out_re = '0;
    out_im = '0;
    for (int k = 0; k < 8; k++) begin
      out_re[k*W +: W] = s3_re[k];
      out_im[k*W +: W] = s3_im[k];
    end
  end

endmodule

// File: tb/tb_fft8_radix2_pipe.sv
// ---------------------------------------------------------------------------
// tb_fft8_radix2_pipe
//
// Directed bench for fft8_radix2_pipe (W=16, TW=16). Two instances share the
// input side: dut (SCALE=0) and dut_s (SCALE=1). Expected spectra are hand
// computed constants; the streaming section keeps an expected queue.
// ---------------------------------------------------------------------------
module tb_fft8_radix2_pipe;

  localparam int W  = 16;
  localparam int TW = 16;
  localparam int FW = 2 * 8 * W;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic           in_valid;
  logic           in_ready;
  logic [8*W-1:0] in_re;
  logic [8*W-1:0] in_im;
  logic           out_valid;
  logic           out_ready;
  logic [8*W-1:0] out_re;
  logic [8*W-1:0] out_im;

  logic           s_in_ready;
  logic           s_out_valid;
  logic [8*W-1:0] s_out_re;
  logic [8*W-1:0] s_out_im;

  fft8_radix2_pipe #(.W(W), .TW(TW), .SCALE(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im)
  );

  fft8_radix2_pipe #(.W(W), .TW(TW), .SCALE(1)) dut_s (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_re    (s_out_re),
    .out_im    (s_out_im)
  );

  // -------------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_err    = 0;
  logic [FW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [FW-1:0] obs,
                     input logic [FW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [8*W-1:0] mk(input int v[8]);
    logic [8*W-1:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[k*W +: W] = v[k][W-1:0];
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one frame for one cycle, then wait (bounded) for out_valid.
  // lat counts rising edges from the accepting edge (1) to the first edge
  // after which out_valid is high.
  task automatic run_frame(input int xr[8], input int xi[8], output int lat);
    in_re    = mk(xr);
    in_im    = mk(xi);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
  endtask

  // -------------------------------------------------------------------------
  // Watchdog
  // -------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    int xr[8];
    int xi[8];
    int er[8];
    int ei[8];
    int sr[8];
    int si[8];
    int lat;
    int sent;
    int rcvd;
    int c;
    logic acc;
    logic [FW-1:0] got;
    logic [FW-1:0] e;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_re", out_re, 0);
    chk("rst_out_im", out_im, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_s_in_ready", s_in_ready, 1);

    // Impulse at x0 -> flat spectrum, latency 3; SCALE=1 gives 1000/8
    xr = '{1000, 0, 0, 0, 0, 0, 0, 0};
    xi = '{default: 0};
    run_frame(xr, xi, lat);
    chk("imp0_latency", lat, 3);
    chk("imp0_s_valid", s_out_valid, 1);
    er = '{default: 1000};
    ei = '{default: 0};
    sr = '{default: 125};
    chk("imp0_re", out_re, mk(er));
    chk("imp0_im", out_im, mk(ei));
    chk("imp0_s_re", s_out_re, mk(sr));
    chk("imp0_s_im", s_out_im, mk(ei));
    step();
    chk("imp0_drained", out_valid, 0);

    // Impulse at x1 -> W8^k rotation through the twiddle multipliers
    xr = '{0, 1000, 0, 0, 0, 0, 0, 0};
    run_frame(xr, xi, lat);
    chk("imp1_latency", lat, 3);
    er = '{1000, 707, 0, -707, -1000, -707, 0, 707};
    ei = '{0, -707, -1000, -707, 0, 707, 1000, 707};
    chk("imp1_re", out_re, mk(er));
    chk("imp1_im", out_im, mk(ei));

    // Impulse at x2 -> W8^(2k) pattern
    xr = '{0, 0, 1000, 0, 0, 0, 0, 0};
    run_frame(xr, xi, lat);
    chk("imp2_latency", lat, 3);
    er = '{1000, 0, -1000, 0, 1000, 0, -1000, 0};
    ei = '{0, -1000, 0, 1000, 0, -1000, 0, 1000};
    chk("imp2_re", out_re, mk(er));
    chk("imp2_im", out_im, mk(ei));

    // Imaginary impulse at x0 -> flat imaginary spectrum; SCALE=1: 500->62
    xr = '{default: 0};
    xi = '{500, 0, 0, 0, 0, 0, 0, 0};
    run_frame(xr, xi, lat);
    er = '{default: 0};
    ei = '{default: 500};
    si = '{default: 62};
    chk("imag_re", out_re, mk(er));
    chk("imag_im", out_im, mk(ei));
    chk("imag_s_im", s_out_im, mk(si));

    // DC input -> energy in bin 0 only
    xr = '{default: 100};
    xi = '{default: 0};
    run_frame(xr, xi, lat);
    er = '{800, 0, 0, 0, 0, 0, 0, 0};
    ei = '{default: 0};
    sr = '{100, 0, 0, 0, 0, 0, 0, 0};
    chk("dc_re", out_re, mk(er));
    chk("dc_im", out_im, mk(ei));
    chk("dc_s_re", s_out_re, mk(sr));
    chk("dc_s_im", s_out_im, mk(ei));

    // Full-scale DC -> overflow in every stage (wrap or clamp)
    xr = '{default: 32767};
    run_frame(xr, xi, lat);
`ifdef FFT8_SATURATE_EN
    er = '{32767, 0, 0, 0, 0, 0, 0, 0};
`else
    er = '{-8, 0, 0, 0, 0, 0, 0, 0};
`endif
    sr = '{32767, 0, 0, 0, 0, 0, 0, 0};
    chk("full_re", out_re, mk(er));
    chk("full_im", out_im, mk(ei));
    chk("full_s_re", s_out_re, mk(sr));
    step();

    // Stream 10 frames back to back; out_ready low in cycles 4..7
    sent = 0;
    rcvd = 0;
    c    = 0;
    xr   = '{default: 0};
    xi   = '{default: 0};
    while (rcvd < 10 && c < 60) begin
      out_ready = !(c >= 4 && c <= 7);
      if (sent < 10) begin
        xr[0]    = 100 * (sent + 1);
        xi[0]    = sent;
        in_re    = mk(xr);
        in_im    = mk(xi);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c >= 4 && c <= 7) chk("stall_in_ready", in_ready, 0);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        got = {out_re, out_im};
        e   = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk("stream_frame", got, e);
        rcvd++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        er = '{default: 100 * (sent + 1)};
        ei = '{default: sent};
        exp_q.push_back({mk(er), mk(ei)});
        sent++;
      end
      c++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_sent", sent, 10);
    chk("stream_rcvd", rcvd, 10);
    chk("stream_q_empty", exp_q.size(), 0);
    step();
    chk("stream_idle", out_valid, 0);

    // Reset with two frames in flight
    xr = '{0, 1000, 0, 0, 0, 0, 0, 0};
    xi = '{default: 0};
    in_re    = mk(xr);
    in_im    = mk(xi);
    in_valid = 1'b1;
    step();
    xr = '{default: 100};
    in_re = mk(xr);
    step();
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_re", out_re, 0);
    chk("midrst_out_im", out_im, 0);
    chk("midrst_in_ready", in_ready, 1);

    // Next frame after reset: normal latency, no leftover output
    xr = '{300, 0, 0, 0, 0, 0, 0, 0};
    xi = '{default: 0};
    run_frame(xr, xi, lat);
    chk("postrst_latency", lat, 3);
    er = '{default: 300};
    ei = '{default: 0};
    chk("postrst_re", out_re, mk(er));
    chk("postrst_im", out_im, mk(ei));
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
